// File: rtl/riscv_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel
// plus the fetched-instruction output channel towards decode.
interface riscv_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    // master: the fetch stage itself
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_inst, if_pc,
        input  if_ready
    );

    // slave: instruction memory plus the decoder
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_inst, if_pc,
        output if_ready
    );
endinterface

// File: rtl/riscv_fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding word fetch with
// redirect/flush support, and a one-entry output register feeding decode.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset_n,
    riscv_fetch_stage_if.master    bus,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            fetch_count,
    output logic [1:0]             state_dbg
);

    // Handshakes: a fetch transfers when imem_req && imem_gnt; the response
    // arrives later as a one-cycle imem_rvalid pulse. An instruction is handed
    // to decode when if_valid && if_ready; while if_valid && !if_ready the
    // output register holds if_inst/if_pc unchanged.

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        out_free;
    logic        req;

    assign out_free = !valid_q || bus.if_ready;
    // Redirect cycles never issue: the target PC is not loaded yet.
    assign req = reset_n && (state == ST_REQ) && out_free && !redirect_valid;

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid_q;
    assign bus.if_inst   = inst_q;
    assign bus.if_pc     = pc_q;
    assign fetch_count   = count_q;
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_REQ;
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc      <= {redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            // Any response still owed for the old stream must be swallowed.
            case (state)
                ST_REQ:  state <= bus.imem_gnt ? ST_DROP : ST_REQ;
                ST_WAIT: state <= bus.imem_rvalid ? ST_REQ : ST_DROP;
                ST_DROP: state <= bus.imem_rvalid ? ST_REQ : ST_DROP;
                default: state <= ST_REQ;
            endcase
        end else begin
            if (valid_q && bus.if_ready) begin
                count_q <= count_q + 32'd1;
                valid_q <= 1'b0;
                inst_q  <= NOP_INST;
            end
            case (state)
                ST_REQ: begin
                    if (req && bus.imem_gnt) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        inst_q  <= bus.imem_rdata;
                        pc_q    <= pc;
                        valid_q <= 1'b1;
                        pc      <= pc + 32'd4;
                        state   <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rvalid) state <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: inputs change on the falling edge,
// outputs are checked 1 ns later, expected values are hand-computed constants.
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  ST_REQ  = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;
    logic [1:0]  state_dbg;

    int n_checks;
    int n_errors;

    riscv_fetch_stage_if bus ();

    riscv_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_count   (fetch_count),
        .state_dbg     (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic rdy);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        bus.if_ready    = rdy;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
        check({tag, "_addr"},  bus.imem_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
        check({tag, "_inst"},  bus.if_inst, NOP);
        check({tag, "_pc"},    bus.if_pc, 32'h0);
        check({tag, "_cnt"},   fetch_count, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_REQ});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc();
        #1;
        check_reset_outputs("rst");

        // Sequential fetch with a 1-cycle memory
        cyc(); reset_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("seq_req0", {31'd0, bus.imem_req}, 32'd1);
        check("seq_addr0", bus.imem_addr, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b1);
        check("seq_wait_req", {31'd0, bus.imem_req}, 32'd0);
        check("seq_wait_state", {30'd0, state_dbg}, {30'd0, ST_WAIT});
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("seq_v0", {31'd0, bus.if_valid}, 32'd1);
        check("seq_pc0", bus.if_pc, 32'h0);
        check("seq_inst0", bus.if_inst, 32'h0050_0093);
        check("seq_cnt0", fetch_count, 32'd0);
        check("seq_req1", {31'd0, bus.imem_req}, 32'd1);
        check("seq_addr1", bus.imem_addr, 32'h4);
        cyc(); drive(1'b0, 1'b1, 32'h00A0_0113, 1'b0, 32'h0, 1'b1);
        check("seq_gap_valid", {31'd0, bus.if_valid}, 32'd0);
        check("seq_gap_inst", bus.if_inst, NOP);
        check("seq_cnt1", fetch_count, 32'd1);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("seq_v1", {31'd0, bus.if_valid}, 32'd1);
        check("seq_pc1", bus.if_pc, 32'h4);
        check("seq_inst1", bus.if_inst, 32'h00A0_0113);
        check("seq_addr2", bus.imem_addr, 32'h8);
        cyc(); drive(1'b0, 1'b1, 32'h0010_8193, 1'b0, 32'h0, 1'b0);
        check("seq_cnt2", fetch_count, 32'd2);

        // Backpressure: decoder stalls for 5 cycles on the third instruction
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            check("bp_valid", {31'd0, bus.if_valid}, 32'd1);
            check("bp_inst", bus.if_inst, 32'h0010_8193);
            check("bp_pc", bus.if_pc, 32'h8);
            check("bp_req", {31'd0, bus.imem_req}, 32'd0);
        end
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("bp_release_req", {31'd0, bus.imem_req}, 32'd1);
        check("bp_release_addr", bus.imem_addr, 32'hC);

        // Grant stall: request and address hold without a grant
        for (int i = 0; i < 4; i++) begin
            cyc(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check("gs_req", {31'd0, bus.imem_req}, 32'd1);
            check("gs_addr", bus.imem_addr, 32'hC);
            check("gs_cnt", fetch_count, 32'd3);
        end

        // Redirect while idle in REQ; low bits of the target are dropped
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b1);
        check("ri_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("ri_addr", bus.imem_addr, 32'h100);
        check("ri_req2", {31'd0, bus.imem_req}, 32'd1);
        check("ri_state", {30'd0, state_dbg}, {30'd0, ST_REQ});
        cyc(); drive(1'b0, 1'b1, 32'h0000_0513, 1'b0, 32'h0, 1'b1);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("ri_pc", bus.if_pc, 32'h100);
        check("ri_inst", bus.if_inst, 32'h0000_0513);
        check("ri_addr_next", bus.imem_addr, 32'h104);

        // Redirect in WAIT; stale response arrives three cycles later
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b1);
        check("rw_req", {31'd0, bus.imem_req}, 32'd0);
        check("rw_cnt", fetch_count, 32'd4);
        for (int i = 0; i < 2; i++) begin
            cyc(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            check("rw_drop_req", {31'd0, bus.imem_req}, 32'd0);
            check("rw_drop_addr", bus.imem_addr, 32'h200);
        end
        cyc(); drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        check("rw_rsp_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rw_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rw_inst", bus.if_inst, NOP);
        check("rw_req2", {31'd0, bus.imem_req}, 32'd1);
        check("rw_addr", bus.imem_addr, 32'h200);
        check("rw_cnt2", fetch_count, 32'd4);

        // Redirect flushes a valid instruction even with if_ready high
        cyc(); drive(1'b0, 1'b1, 32'h00C0_0193, 1'b0, 32'h0, 1'b1);
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b1);
        check("fl_valid", {31'd0, bus.if_valid}, 32'd1);
        check("fl_pc", bus.if_pc, 32'h200);
        check("fl_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("fl_valid2", {31'd0, bus.if_valid}, 32'd0);
        check("fl_inst", bus.if_inst, NOP);
        check("fl_cnt", fetch_count, 32'd4);
        check("fl_addr", bus.imem_addr, 32'h300);

        // Redirect coinciding with rvalid: data discarded, no pc increment
        cyc(); drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0400, 1'b1);
        check("sr_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(); drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("sr_state", {30'd0, state_dbg}, {30'd0, ST_REQ});
        check("sr_req2", {31'd0, bus.imem_req}, 32'd1);
        check("sr_addr", bus.imem_addr, 32'h400);
        check("sr_valid", {31'd0, bus.if_valid}, 32'd0);
        check("sr_inst", bus.if_inst, NOP);
        check("sr_cnt", fetch_count, 32'd4);

        // Asynchronous reset while a request is outstanding
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("mr_state", {30'd0, state_dbg}, {30'd0, ST_WAIT});
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        cyc(); reset_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("mr_req", {31'd0, bus.imem_req}, 32'd1);
        check("mr_addr", bus.imem_addr, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        cyc(); drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("mr_pc", bus.if_pc, 32'h0);
        check("mr_inst", bus.if_inst, 32'h0050_0093);
        check("mr_addr2", bus.imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
